br_multiport_sb: RTL

Parametrised successor to the processor register bank (BR).
- Generalised word width and depth; optional hard-zero register 0; optional write-to-read bypass.
- Adds a per-register pending scoreboard: the decode stage marks destinations of long-latency ops (loads). Writeback clears the mark.
- Busy flags and a pending counter feed the hazard/stall logic.

---
 rtl/br_multiport_sb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/br_multiport_sb.sv
// Register bank with two combinational read ports, one write port and a per-register pending scoreboard.
// Latency: reads, busy flags and bypass are zero-cycle; storage, pend bits and pend_cnt update on the clk edge.
// Backpressure: none; every write and pend_set is accepted, out-of-range or zero-register targets are dropped.
module br_multiport_sb #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [ADDR_W-1:0] a3,
   input  logic [WIDTH-1:0]  wd3,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   pend_cnt
);

   // One-hot decode of an address onto the implemented registers. Addresses at or
   // beyond DEPTH decode to all zeros, and so does register 0 when it is hard-wired,
   // so a zero vector means "no register" everywhere downstream.
   function automatic logic [DEPTH-1:0] reg_dec(input logic [ADDR_W-1:0] a);
      logic [DEPTH-1:0] oh;
      oh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         oh[i] = (a == ADDR_W'(i));
      end
      if (ZERO_REG != 0) begin
         oh[0] = 1'b0;
      end
      return oh;
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] pend;
   logic [ADDR_W:0]  cnt_q;

   logic [DEPTH-1:0] a1_oh;
   logic [DEPTH-1:0] a2_oh;
   logic [DEPTH-1:0] wr_oh;
   logic [DEPTH-1:0] set_oh;
   logic             byp1;
   logic             byp2;
   logic             cnt_inc;
   logic             cnt_dec;

   assign a1_oh  = reg_dec(a1);
   assign a2_oh  = reg_dec(a2);
   assign wr_oh  = we       ? reg_dec(a3)        : '0;
   assign set_oh = pend_set ? reg_dec(pend_addr) : '0;

   // A read port is bypassed when the same register is being written this cycle.
   assign byp1 = (BYPASS != 0) && |(a1_oh & wr_oh);
   assign byp2 = (BYPASS != 0) && |(a2_oh & wr_oh);

   // A new set counts only if the bit was clear; a clear counts only if the bit was
   // set and is not being re-set in the same cycle (the new producer wins).
   assign cnt_inc = |(set_oh & ~pend);
   assign cnt_dec = |(wr_oh & pend & ~set_oh);

   // Read port 1: storage mux, overridden by same-cycle write data when bypassing.
   always_comb begin
      rd1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (a1_oh[i]) begin
            rd1 = mem[i];
         end
      end
      if (byp1) begin
         rd1 = wd3;
      end
   end

   // Read port 2: identical structure to port 1.
   always_comb begin
      rd2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (a2_oh[i]) begin
            rd2 = mem[i];
         end
      end
      if (byp2) begin
         rd2 = wd3;
      end
   end

   // A register is busy while pending, unless the bypassed writeback satisfies it now.
   assign busy1 = |(a1_oh & pend) & ~byp1;
   assign busy2 = |(a2_oh & pend) & ~byp2;

   assign pend_cnt = cnt_q;

   // Register storage: cleared on reset, written only through the writeback port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_oh[i]) begin
               mem[i] <= wd3;
            end
         end
      end
   end

   // Scoreboard bits: writeback clears, issue sets, set applied last so it wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend <= (pend & ~wr_oh) | set_oh;
      end
   end

   // Pending counter tracks the popcount of pend incrementally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         case ({cnt_inc, cnt_dec})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule
